dma_chan_mux: RTL
=================

// Module: dma_chan_mux
// PURPOSE
//  N-channel, parametrised successor of the Main_FSM 2:1 data mux. Selects one of NUM_CH
//  DMA source streams, holds the selection for a whole burst (until last beat), and
//  forwards beats through a registered valid/ready output stage. Sits between the per-
//  channel read engines and the shared AXI4 write-data path.
// PARAMETERS
//  NUM_CH      4   number of input channels (>=2)
//  DATA_WIDTH  32  beat width in bits
//  ARB_MODE    0   0 = round-robin, 1 = fixed priority (lowest index wins)
//  CH_W        $clog2(NUM_CH)  derived localparam, channel-id width
// PORTS
//  clk       in   1                  clock, all logic rising-edge
//  rst       in   1                  synchronous, active-high reset
//  ch_en     in   NUM_CH             per-channel enable mask, sampled during arbitration
//  s_valid   in   NUM_CH             per-channel beat valid
//  s_data    in   NUM_CH*DATA_WIDTH  packed beats, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//  s_last    in   NUM_CH             per-channel last beat of burst
//  s_ready   out  NUM_CH             per-channel ready; at most one bit high
//  m_valid   out  1                  output beat valid (registered)
//  m_data    out  DATA_WIDTH         output beat (registered)
//  m_last    out  1                  output last flag (registered)
//  m_ch      out  CH_W               channel id of current output beat (registered)
//  m_ready   in   1                  downstream ready
//  busy      out  1                  high while a burst is locked (state LOCK)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state IDLE, m_valid=0, m_data=0, m_last=0, m_ch=0, rr_ptr=0,
//    s_ready=0, busy=0. Reset mid-burst drops the burst and any held beat; no partial flush.
//  - FSM IDLE: req = s_valid & ch_en. If req!=0, register grant g, go LOCK. s_ready=0.
//    RR: g = first set bit of req searching from rr_ptr upward with wrap (NUM_CH-1 -> 0).
//    Fixed: g = lowest set bit of req. req==0: stay IDLE.
//  - FSM LOCK: s_ready[g] = !m_valid | m_ready; all other s_ready bits 0. No re-arbitration
//    until the beat with s_last[g]=1 is accepted; then go IDLE and rr_ptr = (g+1) mod NUM_CH
//    (rr_ptr unchanged in fixed mode).
//  - Accept = s_valid[g] & s_ready[g]: next cycle m_valid=1, m_data=s_data[g], m_last=s_last[g],
//    m_ch=g. If m_valid & m_ready and no accept: m_valid clears; data fields hold value.
//  - Output stage: m_valid/m_data/m_last/m_ch hold stable while m_valid & !m_ready (AXI rule).
//    Simultaneous drain + accept in one cycle is legal: throughput 1 beat/cycle in a burst.
//  - Latency: s_valid rising in IDLE -> grant at edge 1 -> accept cycle 1 -> m_valid at edge 2.
//    Back-to-back bursts cost exactly one IDLE arbitration cycle between them.
//  - ch_en affects arbitration only; clearing ch_en[g] during LOCK does not abort the burst.
//  - Single-beat burst (s_last on first beat) is legal: LOCK lasts one accept.
//  - No combinational path from s_valid or m_ready to m_valid; s_ready depends on m_ready only.
//  - busy = (state==LOCK).
// STRUCTURE
//  - Package dma_mux_pkg: typedef enum logic {MUX_IDLE, MUX_LOCK} mux_state_e;
//    typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e; ARB_MODE compared against these.
//  - Sub-module dma_rr_arbiter (NUM_CH, ARB_MODE): combinational req/ptr -> one-hot grant +
//    index + any_grant. FSM, rr_ptr and output register live in dma_chan_mux.
// TESTING (NUM_CH=4, DATA_WIDTH=32)
//  - Reset: rst=1 two cycles with all s_valid=1 -> m_valid=0, s_ready=0, busy=0, m_ch=0.
//  - RR fairness: ch0..ch3 always valid, 2-beat bursts, m_ready=1 -> m_ch sequence
//    0,0,1,1,2,2,3,3,0,... with one idle cycle between bursts.
//  - Fixed mode: ch1 and ch3 valid together, ARB_MODE=1 -> ch1 burst first; ch0 raised
//    mid-burst of ch1 is not granted until ch1 s_last accepted, then ch0 before ch3.
//  - Backpressure: burst on ch2 data 0xA0..0xA3, m_ready low 3 cycles on beat 1 -> m_data=0xA1
//    held stable, s_ready[2]=0 while stalled, all 4 beats delivered in order, m_last on 0xA3.
//  - Enable mask: ch_en=4'b1011, ch2 valid alone -> stays IDLE; clear ch_en[0] during ch0
//    burst -> burst completes all beats.
//  - Reset mid-burst: rst=1 during beat 2 of 4 -> next cycle m_valid=0, state IDLE, rr_ptr=0.

Source files
------------

// File: rtl/dma_mux_pkg.sv
// Shared types for the DMA channel mux: FSM states and arbitration modes.
package dma_mux_pkg;

  typedef enum logic {
    MUX_IDLE = 1'b0,
    MUX_LOCK = 1'b1
  } mux_state_e;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Combinational channel arbiter: round-robin from a pointer, or fixed lowest-index priority.
module dma_rr_arbiter
  import dma_mux_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  parameter int  ARB_MODE = 0,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [CH_W-1:0]   o_grant_idx,
  output logic              o_any
);

  localparam bit IS_FIXED = (ARB_MODE == int'(ARB_FIXED));

  logic [CH_W-1:0] w_idx;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see earlier results.
    // NOTE: every output gets a default before the loop, otherwise a latch is inferred.
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = IS_FIXED ? CH_W'(k) : CH_W'((int'(i_ptr) + k) % NUM_CH);
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/dma_chan_mux.sv
// N-channel DMA stream mux: locks one channel per burst and forwards beats
// through a registered valid/ready output stage.
module dma_chan_mux
  import dma_mux_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  DATA_WIDTH = 32,
  parameter int  ARB_MODE   = 0,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH-1:0]            s_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_CH-1:0]            s_last,
  output logic [NUM_CH-1:0]            s_ready,
  output logic                         m_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_last,
  output logic [CH_W-1:0]              m_ch,
  input  logic                         m_ready,
  output logic                         busy
);

  localparam bit IS_FIXED = (ARB_MODE == int'(ARB_FIXED));

  mux_state_e            r_state;
  logic [CH_W-1:0]       r_grant;
  logic [NUM_CH-1:0]     r_grant_oh;
  logic [CH_W-1:0]       r_rr_ptr;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_last;
  logic [CH_W-1:0]       r_m_ch;

  logic [NUM_CH-1:0]     w_arb_oh;
  logic [CH_W-1:0]       w_arb_idx;
  logic                  w_arb_any;
  logic                  w_out_free;
  logic                  w_accept;
  logic                  w_sel_last;
  logic [CH_W-1:0]       w_next_ptr;
  logic [DATA_WIDTH-1:0] w_beat [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign w_beat[i] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  dma_rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .i_req       (s_valid & ch_en),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_arb_oh),
    .o_grant_idx (w_arb_idx),
    .o_any       (w_arb_any)
  );

  // Output slot is free when empty or being drained this cycle; s_ready sees only m_ready.
  assign w_out_free = !r_m_valid || m_ready;
  assign s_ready    = (r_state == MUX_LOCK && w_out_free) ? r_grant_oh : '0;
  assign w_accept   = (r_state == MUX_LOCK) && s_valid[r_grant] && w_out_free;
  assign w_sel_last = s_last[r_grant];
  assign w_next_ptr = (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
    if (rst) begin
      r_state    <= MUX_IDLE;
      r_grant    <= '0;
      r_grant_oh <= '0;
      r_rr_ptr   <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_last   <= 1'b0;
      r_m_ch     <= '0;
    end else begin
      if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_beat[r_grant];
        r_m_last  <= w_sel_last;
        r_m_ch    <= r_grant;
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end

      case (r_state)
        MUX_IDLE: begin
          if (w_arb_any) begin
            r_grant    <= w_arb_idx;
            r_grant_oh <= w_arb_oh;
            r_state    <= MUX_LOCK;
          end
        end
        MUX_LOCK: begin
          // Burst ends only when its last beat is actually taken.
          if (w_accept && w_sel_last) begin
            r_state <= MUX_IDLE;
            if (!IS_FIXED) r_rr_ptr <= w_next_ptr;
          end
        end
      endcase
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;
  assign m_ch    = r_m_ch;
  assign busy    = (r_state == MUX_LOCK);

endmodule
